// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// alu_rr_scheduler : round-robin front end sharing one combinational ALU
// Revision 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 64,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*2-1:0]     req_sel,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      alu_p,
   output logic [WIDTH-1:0]      alu_q,
   output logic [1:0]            alu_select,
   input  logic [WIDTH-1:0]      alu_z,
   input  logic                  alu_cout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_carry,
   output logic                  busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       r_state;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_id;
   logic [WIDTH-1:0] r_alu_p;
   logic [WIDTH-1:0] r_alu_q;
   logic [1:0]       r_alu_select;
   logic             r_rsp_valid;
   logic [IDW-1:0]   r_rsp_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_carry;

   logic             w_found;
   logic [IDW-1:0]   w_win;
   logic [IDW-1:0]   w_idx;
   logic [IDW-1:0]   w_ptr_next;

   // First pending requester at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = IDW'((int'(r_ptr) + k) % NREQ);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_ptr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

   always_comb begin
      gnt = '0;
      if (!reset && (r_state == S_IDLE) && w_found) begin
         gnt = NREQ'(1) << w_win;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_id         <= '0;
         r_alu_p      <= '0;
         r_alu_q      <= '0;
         r_alu_select <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_data   <= '0;
         r_rsp_carry  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_alu_p      <= req_a[w_win*WIDTH +: WIDTH];
                  r_alu_q      <= req_b[w_win*WIDTH +: WIDTH];
                  r_alu_select <= req_sel[w_win*2 +: 2];
                  r_id         <= w_win;
                  r_ptr        <= w_ptr_next;
                  r_state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               // Carry is only meaningful for the arithmetic functions.
               r_rsp_data  <= alu_z;
               r_rsp_carry <= alu_cout & r_alu_select[1];
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_p      = r_alu_p;
   assign alu_q      = r_alu_q;
   assign alu_select = r_alu_select;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_data   = r_rsp_data;
   assign rsp_carry  = r_rsp_carry;
   assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
